dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port, word-wide data memory between two requesters: m0 (core load/store unit) and m1 (debug/loader port).
- Round-robin arbitration with valid/ready request handshakes and a fixed-latency response pulse.
- Byte/halfword stores are done as read-modify-write, because the memory only writes whole words.
- Sits between the requesters and the memory's byte_address/write_data/MemWrite/MemRead/output_data interface.

Parameters:
- ADDR_W, 32, request and memory address width
- DATA_W, 32, data width; must be 32 (four byte lanes)

Ports:
- clk  in  1  single clock; all state on its rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req_valid  in  1  m0 request present
- m0_req_ready  out  1  m0 request accepted this cycle
- m0_req_addr  in  ADDR_W  byte address; bits [1:0] ignored
- m0_req_we  in  1  1 = store, 0 = load
- m0_req_be  in  4  byte enables for store, lane i = bits [8i+7:8i]
- m0_req_wdata  in  DATA_W  store data, lane-aligned
- m0_rsp_valid  out  1  one-cycle response pulse
- m0_rsp_rdata  out  DATA_W  word read at the address (pre-store value for stores)
- m1_* : same eight signals as m0_*, for requester m1
- mem_byte_address  out  ADDR_W  to memory byte_address
- mem_write_data  out  DATA_W  to memory write_data
- mem_MemWrite  out  1  to memory MemWrite
- mem_MemRead  out  1  to memory MemRead
- mem_output_data  in  DATA_W  from memory; combinational read of current address

Behaviour:
- Reset values: state=IDLE; last-grant pointer=m1, so m0 wins the first tie.
- Reset values of outputs: all ready/rsp_valid/MemWrite/MemRead 0; rsp_rdata 0; mem_byte_address 0; mem_write_data 0.
- FSM state IDLE:
  - Arbitrate combinationally over the valid signals.
  - Only one valid: grant it. Both valid: grant the requester that is not last-grant.
  - Assert the granted port's req_ready in the same cycle.
  - Latch addr (bits [1:0] forced 0), we, be, wdata and the owner; update last-grant; go to READ.
  - No valid: stay.
- FSM state READ:
  - Drive mem_byte_address = latched addr and mem_MemRead=1.
  - Capture mem_output_data into rdata_q.
  - If we=1 and be!=0: go to MERGE; otherwise go to RESP.
- FSM state MERGE:
  - Drive MemWrite=1, same address.
  - write_data lane i = be[i] ? wdata_q lane i : rdata_q lane i (full-word be=4'hF is a plain write).
  - Go to RESP.
- FSM state RESP:
  - Owner's rsp_valid=1 for exactly one cycle; rsp_rdata=rdata_q. Go to IDLE.
- Latency, counted from the accept cycle N: load rsp_valid at N+2; store rsp_valid at N+3.
- Next acceptance no earlier than cycle N+3 (load) or N+4 (store). req_ready never asserts outside IDLE.
- Handshake:
  - A requester must hold valid and payload stable until ready.
  - Deasserting valid before ready is allowed; nothing is latched.
  - Responses have no backpressure.
- rsp_rdata holds its last value between pulses. The non-owner's rsp_valid stays 0.
- Store with we=1, be=0: no memory write; a response is still returned at N+2 (load timing).
- mem_MemRead/mem_MemWrite are 0 in IDLE and RESP. mem_byte_address holds the latched address outside IDLE.
- Address wrap-around is the memory's concern; the arbiter passes ADDR_W bits unchanged apart from bits [1:0].
- Reset mid-operation: the FSM returns to IDLE and memory strobes drop immediately.
  - The in-flight request is dropped with no response.
  - A MERGE interrupted before the clock edge writes nothing.
- Starvation bound: a continuously valid requester is granted within two arbitration rounds.

Optional Feature:
- Macro DMEM_ARBITER_STATS_EN.
- Defined:
  - Adds output ports stat_grant_m0, stat_grant_m1 and stat_wait_cycles, each 16 bits, all reset to 0 and saturating at 16'hFFFF.
  - stat_grant_m0/stat_grant_m1 increment per grant.
  - stat_wait_cycles increments each cycle some req_valid=1 while that requester's req_ready=0.
- Not defined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package dmem_arbiter_pkg holds:
  - state enum {IDLE, READ, MERGE, RESP}
  - owner_e {OWN_M0, OWN_M1}
  - BYTE_LANES=4
  - a byte-merge function merge(old, new, be)
- Sub-module rr_arb2:
  - Combinational two-way round-robin grant from the valid signals plus the last-grant register.
  - Grant qualified by an enable (state==IDLE).
  - Last-grant update on accept.

Test Plan:
- Load: mem[0x10>>2]=32'hDEADBEEF; m0 load addr 0x10 -> m0_req_ready at N, m0_rsp_valid at N+2 with rdata 32'hDEADBEEF; MemWrite never 1.
- Byte store: mem word 32'h11223344; m1 store addr 0x20, be=4'b0010, wdata=32'h0000AA00 -> MemWrite only at N+2, written 32'h1122AA44, m1_rsp_rdata=32'h11223344 at N+3.
- Contention: both valid from reset for 4 requests each -> grants alternate m0,m1,m0,m1...; first grant m0; no rsp_valid on the wrong port.
- No-op store: m0 store be=4'b0000 -> no MemWrite, m0_rsp_valid at N+2, memory unchanged.
- Async reset: assert rst mid-MERGE, between clock edges -> MemWrite falls immediately; no response; memory word unchanged; next request after reset granted to m0.
- Stats (macro defined): 3 m0 grants, 2 m1 grants, m1 held waiting 5 cycles -> stat_grant_m0=3, stat_grant_m1=2, stat_wait_cycles=5.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Stats counters are enabled with DMEM_ARBITER_STATS_EN.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        MERGE,
        RESP
    } state_e;

    typedef enum logic {
        OWN_M0,
        OWN_M1
    } owner_e;

    localparam int BYTE_LANES = 4;

    function automatic logic [31:0] merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-grant pointer.
// The pointer resets to m1 so m0 wins the first tie.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   valid0,
    input  logic   valid1,
    output logic   gnt0,
    output logic   gnt1,
    output logic   accept,
    output owner_e gnt_owner
);

    owner_e last_q;

    assign gnt0 = en & valid0 & (~valid1 | (last_q == OWN_M1));
    assign gnt1 = en & valid1 & (~valid0 | (last_q == OWN_M0));
    assign accept = gnt0 | gnt1;
    assign gnt_owner = gnt1 ? OWN_M1 : OWN_M0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= OWN_M1;
        end else if (accept) begin
            last_q <= gnt_owner;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a word-wide single-port data memory.
// Optional DMEM_ARBITER_STATS_EN adds grant/wait counters.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
`ifdef DMEM_ARBITER_STATS_EN
    output logic [15:0]       stat_grant_m0,
    output logic [15:0]       stat_grant_m1,
    output logic [15:0]       stat_wait_cycles,
`endif
    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic              m0_req_we,
    input  logic [3:0]        m0_req_be,
    input  logic [DATA_W-1:0] m0_req_wdata,
    output logic              m0_rsp_valid,
    output logic [DATA_W-1:0] m0_rsp_rdata,
    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic              m1_req_we,
    input  logic [3:0]        m1_req_be,
    input  logic [DATA_W-1:0] m1_req_wdata,
    output logic              m1_rsp_valid,
    output logic [DATA_W-1:0] m1_rsp_rdata,
    output logic [ADDR_W-1:0] mem_byte_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_MemWrite,
    output logic              mem_MemRead,
    input  logic [DATA_W-1:0] mem_output_data
);

    state_e            state_q;
    state_e            state_d;
    owner_e            owner_q;
    owner_e            gnt_owner;
    logic              gnt0;
    logic              gnt1;
    logic              accept;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] m0_hold_q;
    logic [DATA_W-1:0] m1_hold_q;
    logic [ADDR_W-1:0] addr_sel;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (state_q == IDLE),
        .valid0    (m0_req_valid),
        .valid1    (m1_req_valid),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .accept    (accept),
        .gnt_owner (gnt_owner)
    );

    assign addr_sel = gnt1 ? m1_req_addr : m0_req_addr;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = READ;
            READ:    state_d = (we_q && be_q != 4'h0) ? MERGE : RESP;
            MERGE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Word-align the address on capture; the memory only sees words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q   <= OWN_M0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= 4'h0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            m0_hold_q <= '0;
            m1_hold_q <= '0;
        end else begin
            if (accept) begin
                owner_q <= gnt_owner;
                addr_q  <= addr_sel & ~ADDR_W'(3);
                we_q    <= gnt1 ? m1_req_we    : m0_req_we;
                be_q    <= gnt1 ? m1_req_be    : m0_req_be;
                wdata_q <= gnt1 ? m1_req_wdata : m0_req_wdata;
            end
            if (state_q == READ) begin
                rdata_q <= mem_output_data;
            end
            if (state_q == RESP) begin
                if (owner_q == OWN_M0) m0_hold_q <= rdata_q;
                else                   m1_hold_q <= rdata_q;
            end
        end
    end

    assign m0_req_ready = gnt0;
    assign m1_req_ready = gnt1;

    assign m0_rsp_valid = (state_q == RESP) && (owner_q == OWN_M0);
    assign m1_rsp_valid = (state_q == RESP) && (owner_q == OWN_M1);
    assign m0_rsp_rdata = m0_rsp_valid ? rdata_q : m0_hold_q;
    assign m1_rsp_rdata = m1_rsp_valid ? rdata_q : m1_hold_q;

    assign mem_byte_address = addr_q;
    assign mem_MemRead      = (state_q == READ);
    assign mem_MemWrite     = (state_q == MERGE);
    assign mem_write_data   = merge(rdata_q, wdata_q, be_q);

`ifdef DMEM_ARBITER_STATS_EN
    logic waiting;

    assign waiting = (m0_req_valid & ~gnt0) | (m1_req_valid & ~gnt1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grant_m0    <= '0;
            stat_grant_m1    <= '0;
            stat_wait_cycles <= '0;
        end else begin
            if (gnt0 && stat_grant_m0 != 16'hFFFF)
                stat_grant_m0 <= stat_grant_m0 + 16'd1;
            if (gnt1 && stat_grant_m1 != 16'hFFFF)
                stat_grant_m1 <= stat_grant_m1 + 16'd1;
            if (waiting && stat_wait_cycles != 16'hFFFF)
                stat_wait_cycles <= stat_wait_cycles + 16'd1;
        end
    end
`endif

endmodule
